formation_scheduler: RTL
========================

Name: formation_scheduler

Overview:
- Sequences an invader formation of ROWS x COLS cells sharing one origin: spawn, horizontal march, edge descent, wave clear and game over.
- Time-multiplexes a single projectile-vs-cell hit comparator across all cells, one cell per cycle.
- Keeps the per-cell alive mask, score and wave count.
- Sits between the projectile unit and the enemy renderer; the renderer draws each live cell from origin_x/origin_y plus fixed pitches.

Parameters:
- ROWS, 3, formation rows.
- COLS, 5, formation columns; N = ROWS*COLS cells, index = row*COLS + col.
- COL_PITCH, 40, x spacing between columns (px).
- ROW_PITCH, 30, y spacing between rows (px).
- X_MIN, 96, leftmost origin_x.
- X_MAX, 389, rightmost origin_x.
- SPAWN_X, 100, origin_x at spawn.
- SPAWN_Y, 10, origin_y at spawn.
- DESCEND, 5, y increment per edge bounce.
- Y_LIMIT, 400, bottom-row y at which the game ends.
- STEP_DIV, 8, tick enables per march step in wave 0.
- HIT_POINTS, 50, score per kill.

Ports:
- dclk  in  1  system clock; all logic on its rising edge.
- clr  in  1  synchronous, active-low reset.
- play  in  1  game running; low forces IDLE.
- tick  in  1  one-cycle game-rate enable.
- proj_valid  in  1  projectile in flight.
- projectile_x  in  10  projectile centre x.
- projectile_y  in  10  projectile centre y.
- origin_x  out  10  formation origin x (cell 0 centre).
- origin_y  out  10  formation origin y (cell 0 top).
- alive  out  ROWS*COLS  per-cell alive mask.
- hit_pulse  out  1  one-cycle kill strobe; the projectile unit retires the shot on it.
- hit_index  out  4  index of the cell killed; valid with hit_pulse.
- score  out  14  accumulated score.
- wave  out  4  wave number.
- wave_clear  out  1  one-cycle strobe when all cells are dead.
- game_over  out  1  sticky game-over flag.

Behaviour:
- Reset (clr=0 at an edge): state=IDLE, origin=(SPAWN_X,SPAWN_Y), alive=0, score=0, wave=0, direction=right, step_cnt=0, scan_idx=0, hit_lock=0. hit_pulse, wave_clear and game_over are all 0.
- States: IDLE, SPAWN, MARCH, DESCEND, CLEAR, OVER.
- IDLE: outputs hold their reset values. play=1 -> SPAWN.
- play=0 in any state: next cycle IDLE with the full reset values, except score, which holds until the next SPAWN out of IDLE. Score is zeroed on that SPAWN.
- SPAWN (1 cycle): origin=(SPAWN_X,SPAWN_Y), alive=all ones, direction=right, step_cnt=0 -> MARCH.
- MARCH:
  - On tick, step_cnt increments.
  - When step_cnt reaches period-1, where period = STEP_DIV >> min(wave,3) with a minimum of 1, step_cnt clears and a step occurs.
  - Step when direction=right and origin_x < X_MAX: origin_x += 1. Step when direction=left and origin_x > X_MIN: origin_x -= 1.
  - Step otherwise: go to DESCEND.
- DESCEND (1 cycle): origin_y += DESCEND, direction flips -> MARCH.
  - If the new bottom-row y, origin_y + (ROWS-1)*ROW_PITCH, is >= Y_LIMIT, go to OVER instead.
- Hit scanner (active in MARCH and DESCEND):
  - scan_idx advances 0..N-1 every cycle and wraps to 0.
  - Cell centre: cx = origin_x + col*COL_PITCH, cy = origin_y + row*ROW_PITCH, computed at 11 bits with no wrap.
  - Hit when all hold: proj_valid, hit_lock=0, alive[scan_idx], py > cy, py - cy < 20, |px - cx| < 15. Compare in 11-bit signed to avoid underflow.
  - On a hit, next edge: alive[scan_idx] <= 0, hit_pulse=1 for 1 cycle, hit_index=scan_idx, score += HIT_POINTS (saturate at 16383), hit_lock=1.
  - hit_lock clears when proj_valid=0, so one shot scores at most once.
  - Full-mask latency: at most N cycles from the projectile entering a cell until hit_pulse.
- Wave clear: when alive becomes 0 in MARCH/DESCEND, go to CLEAR. wave_clear=1 for 1 cycle, wave += 1 (saturate at 15) -> SPAWN.
- A hit on the last cell and a DESCEND into Y_LIMIT in the same cycle: the clear wins; no game over.
- OVER: game_over=1 sticky. Formation is frozen, scanner disabled. Exit only via play=0 or reset.
- A tick during DESCEND/SPAWN/CLEAR is dropped; step_cnt holds.

Test Plan:
- Reset, play=1, no tick -> after 2 cycles: state MARCH, alive=15'h7FFF, origin=(100,10), score=0.
- tick every cycle, wave 0 -> origin_x increments once per 8 ticks. At 389, the next step gives origin_y=15 and direction=left. The following step gives origin_x=388.
- proj_valid=1, projectile=(140,25) held for 30 cycles -> exactly one hit_pulse with hit_index=1. Then alive[1]=0, score=50; hit_lock blocks further hits until proj_valid=0.
- Force 14 kills, then kill the last cell -> wave_clear pulse, wave=1, SPAWN with alive all ones; march period is now 4 ticks.
- Run descents until origin_y+60 >= 400 -> game_over=1, origin frozen; play=0 -> IDLE next cycle, game_over=0.
- clr=0 mid-MARCH with score=100 -> next edge: all outputs at their reset values, including score=0.

Source files
------------

// File: rtl/formation_scheduler.sv
// Invader formation sequencer: spawn/march/descend/clear/over FSM plus a
// time-multiplexed projectile-vs-cell hit scanner, alive mask, score and wave.
module formation_scheduler #(
   parameter int ROWS       = 3,
   parameter int COLS       = 5,
   parameter int COL_PITCH  = 40,
   parameter int ROW_PITCH  = 30,
   parameter int X_MIN      = 96,
   parameter int X_MAX      = 389,
   parameter int SPAWN_X    = 100,
   parameter int SPAWN_Y    = 10,
   parameter int DESCEND    = 5,
   parameter int Y_LIMIT    = 400,
   parameter int STEP_DIV   = 8,
   parameter int HIT_POINTS = 50
) (
   input  logic                 dclk,
   input  logic                 clr,
   input  logic                 play,
   input  logic                 tick,
   input  logic                 proj_valid,
   input  logic [9:0]           projectile_x,
   input  logic [9:0]           projectile_y,
   output logic [9:0]           origin_x,
   output logic [9:0]           origin_y,
   output logic [ROWS*COLS-1:0] alive,
   output logic                 hit_pulse,
   output logic [3:0]           hit_index,
   output logic [13:0]          score,
   output logic [3:0]           wave,
   output logic                 wave_clear,
   output logic                 game_over
);
   localparam int N  = ROWS * COLS;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int SW = $clog2(STEP_DIV + 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_SPAWN = 3'd1;
   localparam logic [2:0] ST_MARCH = 3'd2;
   localparam logic [2:0] ST_DESC  = 3'd3;
   localparam logic [2:0] ST_CLEAR = 3'd4;
   localparam logic [2:0] ST_OVER  = 3'd5;

   localparam logic [9:0]  XMIN    = 10'(X_MIN);
   localparam logic [9:0]  XMAX    = 10'(X_MAX);
   localparam logic [9:0]  SX      = 10'(SPAWN_X);
   localparam logic [9:0]  SY      = 10'(SPAWN_Y);
   localparam logic [9:0]  DY      = 10'(DESCEND);
   localparam logic [10:0] BOT_OFS = 11'((ROWS - 1) * ROW_PITCH);
   localparam logic [10:0] YLIM    = 11'(Y_LIMIT);
   localparam logic [10:0] CPITCH  = 11'(COL_PITCH);
   localparam logic [10:0] RPITCH  = 11'(ROW_PITCH);
   localparam logic [14:0] PTS     = 15'(HIT_POINTS);

   logic [2:0]         state;
   logic               dir_left;
   logic [SW-1:0]      step_cnt;
   logic [SW-1:0]      period;
   logic [3:0]         scan_idx;
   logic [RW-1:0]      scan_row;
   logic [CW-1:0]      scan_col;
   logic               hit_lock;
   logic [1:0]         wshift;
   logic [10:0]        cx, cy, bottom;
   logic signed [10:0] dx, dy;
   logic [N-1:0]       kill_mask;
   logic [14:0]        score_sum;
   logic [9:0]         new_y;
   logic               scanning, hit, all_dead, at_edge, step, past_limit;

   // March period halves per wave, bottoming out after wave 3.
   always_comb begin
      wshift = (wave > 4'd3) ? 2'd3 : wave[1:0];
      period = SW'(STEP_DIV >> wshift);
      if (period == '0) period = SW'(1);
   end

   assign scanning = (state == ST_MARCH) || (state == ST_DESC);
   assign cx       = {1'b0, origin_x} + 11'(scan_col) * CPITCH;
   assign cy       = {1'b0, origin_y} + 11'(scan_row) * RPITCH;
   assign dx       = $signed({1'b0, projectile_x}) - $signed(cx);
   assign dy       = $signed({1'b0, projectile_y}) - $signed(cy);
   assign hit      = scanning && proj_valid && !hit_lock && alive[scan_idx] &&
                     (dy > 11'sd0) && (dy < 11'sd20) && (dx > -11'sd15) && (dx < 11'sd15);

   assign kill_mask  = hit ? (N'(1) << scan_idx) : '0;
   assign all_dead   = ((alive & ~kill_mask) == '0);
   assign at_edge    = dir_left ? (origin_x <= XMIN) : (origin_x >= XMAX);
   assign step       = (step_cnt == period - SW'(1));
   assign new_y      = origin_y + DY;
   assign bottom     = {1'b0, new_y} + BOT_OFS;
   assign past_limit = (bottom >= YLIM);
   assign score_sum  = {1'b0, score} + PTS;
   assign game_over  = (state == ST_OVER);

   always_ff @(posedge dclk) begin
      hit_pulse  <= 1'b0;
      wave_clear <= 1'b0;
      if (!clr || !play) begin
         // Dropping play returns to IDLE like reset, but the score survives
         // so it can be shown until the next game starts.
         state     <= ST_IDLE;
         origin_x  <= SX;
         origin_y  <= SY;
         alive     <= '0;
         wave      <= '0;
         dir_left  <= 1'b0;
         step_cnt  <= '0;
         scan_idx  <= '0;
         scan_row  <= '0;
         scan_col  <= '0;
         hit_lock  <= 1'b0;
         hit_index <= '0;
         if (!clr) score <= '0;
      end else begin
         if (!proj_valid) hit_lock <= 1'b0;
         if (scanning) begin
            if (scan_idx == 4'(N - 1)) begin
               scan_idx <= '0;
               scan_row <= '0;
               scan_col <= '0;
            end else begin
               scan_idx <= scan_idx + 4'd1;
               if (scan_col == CW'(COLS - 1)) begin
                  scan_col <= '0;
                  scan_row <= scan_row + RW'(1);
               end else begin
                  scan_col <= scan_col + CW'(1);
               end
            end
            if (hit) begin
               alive     <= alive & ~kill_mask;
               hit_pulse <= 1'b1;
               hit_index <= scan_idx;
               score     <= score_sum[14] ? 14'h3FFF : score_sum[13:0];
               hit_lock  <= 1'b1;
            end
         end
         case (state)
            ST_IDLE: begin
               score <= '0;
               state <= ST_SPAWN;
            end
            ST_SPAWN: begin
               origin_x <= SX;
               origin_y <= SY;
               alive    <= '1;
               dir_left <= 1'b0;
               step_cnt <= '0;
               state    <= ST_MARCH;
            end
            ST_MARCH: begin
               if (all_dead) begin
                  state <= ST_CLEAR;
               end else if (tick) begin
                  if (step) begin
                     step_cnt <= '0;
                     if (at_edge)       state    <= ST_DESC;
                     else if (dir_left) origin_x <= origin_x - 10'd1;
                     else               origin_x <= origin_x + 10'd1;
                  end else begin
                     step_cnt <= step_cnt + SW'(1);
                  end
               end
            end
            ST_DESC: begin
               origin_y <= new_y;
               dir_left <= ~dir_left;
               // A last-cell kill here takes priority over reaching the limit.
               if (all_dead)        state <= ST_CLEAR;
               else if (past_limit) state <= ST_OVER;
               else                 state <= ST_MARCH;
            end
            ST_CLEAR: begin
               wave       <= (wave == 4'hF) ? wave : wave + 4'd1;
               wave_clear <= 1'b1;
               state      <= ST_SPAWN;
            end
            default: ;
         endcase
      end
   end
endmodule
